// File: rtl/reg_file_16x16.sv
// reg_file_16x16: sixteen-entry general-purpose register file for the 16-bit
// datapath. It has one synchronous write-back port and two combinational read
// ports with write-through bypass. A processor status (flags) register sits
// alongside, and a saturating debug counter tracks committed writes.
module reg_file_16x16 #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 16,
    parameter int ADDR_W = 4,
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrEnable,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [WIDTH-1:0]  wrData,
    input  logic [ADDR_W-1:0] rdAddrA,
    input  logic [ADDR_W-1:0] rdAddrB,
    input  logic              flagsWrite,
    input  logic [FLAG_W-1:0] flagsIn,
    output logic [WIDTH-1:0]  regA,
    output logic [WIDTH-1:0]  regB,
    output logic [FLAG_W-1:0] flagsOut,
    output logic [7:0]        wrCount
);

    logic [WIDTH-1:0] regs [NREGS];

    // Write-back port: every register, r0 included, is writable; reset clears the whole array
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEnable) begin
            regs[wrAddr] <= wrData;
        end
    end

    // Flags are latched from the ALU on strobe; the output shows only the stored value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flagsOut <= '0;
        end else if (flagsWrite) begin
            flagsOut <= flagsIn;
        end
    end

    // Committed-write counter, held at 255 instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrCount <= '0;
        end else if (wrEnable && (wrCount != 8'hFF)) begin
            wrCount <= wrCount + 8'd1;
        end
    end

    // Read ports forward the in-flight write-back value so a dependent operand sees it this cycle
    always_comb begin
        regA = regs[rdAddrA];
        regB = regs[rdAddrB];
        if (wrEnable && (rdAddrA == wrAddr)) begin
            regA = wrData;
        end
        if (wrEnable && (rdAddrB == wrAddr)) begin
            regB = wrData;
        end
        // reset must win over bypass while it is held high
        if (reset) begin
            regA = '0;
            regB = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_16x16.sv
// tb_reg_file_16x16: directed scoreboard bench for reg_file_16x16.
// Stimulus pushes expected values into a queue. A monitor process drains the
// queue on each sample strobe and compares against the DUT outputs.
module tb_reg_file_16x16;

    logic        clk = 1'b0;
    logic        reset;
    logic        wrEnable;
    logic [3:0]  wrAddr;
    logic [15:0] wrData;
    logic [3:0]  rdAddrA;
    logic [3:0]  rdAddrB;
    logic        flagsWrite;
    logic [4:0]  flagsIn;
    logic [15:0] regA;
    logic [15:0] regB;
    logic [4:0]  flagsOut;
    logic [7:0]  wrCount;

    reg_file_16x16 dut (
        .clk        (clk),
        .reset      (reset),
        .wrEnable   (wrEnable),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .rdAddrA    (rdAddrA),
        .rdAddrB    (rdAddrB),
        .flagsWrite (flagsWrite),
        .flagsIn    (flagsIn),
        .regA       (regA),
        .regB       (regB),
        .flagsOut   (flagsOut),
        .wrCount    (wrCount)
    );

    always #5 clk = ~clk;

    typedef enum int { SEL_A, SEL_B, SEL_FLAGS, SEL_CNT } sel_t;

    typedef struct {
        sel_t        sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t  sb_q[$];
    event  sample_ev;
    int    checks = 0;
    int    errors = 0;
    int    data_ctr;

    // Monitor: on each sample strobe, pop every pending expectation and compare
    initial begin
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [15:0] act;
                e = sb_q.pop_front();
                case (e.sel)
                    SEL_A:     act = regA;
                    SEL_B:     act = regB;
                    SEL_FLAGS: act = {11'd0, flagsOut};
                    default:   act = {8'd0, wrCount};
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s actual=%h expected=%h @%0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic expect_val(input sel_t sel, input logic [15:0] exp, input string name);
        exp_t e;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle, fire the monitor, then move on
    task automatic sample_now();
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic write_burst(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            wrEnable = 1'b1;
            wrAddr   = 4'd0;
            wrData   = data_ctr[15:0];
            data_ctr++;
        end
        @(negedge clk);
        wrEnable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wrEnable = 1'b0; wrAddr = '0; wrData = '0;
        rdAddrA = '0; rdAddrB = '0; flagsWrite = 1'b0; flagsIn = '0;
        data_ctr = 0;

        // Reset state
        @(negedge clk);
        expect_val(SEL_A, 16'h0000, "reset_regA");
        expect_val(SEL_B, 16'h0000, "reset_regB");
        expect_val(SEL_FLAGS, 16'h0000, "reset_flags");
        expect_val(SEL_CNT, 16'h0000, "reset_wrCount");
        sample_now();
        reset = 1'b0;

        // Write r3 and flags, then assert reset asynchronously mid-cycle
        @(negedge clk);
        wrEnable = 1'b1; wrAddr = 4'd3; wrData = 16'hBEEF;
        flagsWrite = 1'b1; flagsIn = 5'b11011;
        @(negedge clk);
        wrEnable = 1'b0; flagsWrite = 1'b0; rdAddrA = 4'd3;
        expect_val(SEL_A, 16'hBEEF, "r3_before_reset");
        expect_val(SEL_FLAGS, 16'h001B, "flags_before_reset");
        expect_val(SEL_CNT, 16'h0001, "cnt_before_reset");
        sample_now();
        reset = 1'b1;
        expect_val(SEL_A, 16'h0000, "async_reset_regA");
        expect_val(SEL_FLAGS, 16'h0000, "async_reset_flags");
        expect_val(SEL_CNT, 16'h0000, "async_reset_wrCount");
        sample_now();
        reset = 1'b0;
        expect_val(SEL_A, 16'h0000, "r3_after_reset_release");
        sample_now();

        // Write r0..r15 with 0x1000+i on successive edges
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wrEnable = 1'b1; wrAddr = 4'(i); wrData = 16'h1000 + 16'(i);
        end
        @(negedge clk);
        wrEnable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rdAddrA = 4'(i);
            rdAddrB = 4'(15 - i);
            expect_val(SEL_A, 16'h1000 + 16'(i), $sformatf("sweepA_r%0d", i));
            expect_val(SEL_B, 16'h1000 + 16'(15 - i), $sformatf("sweepB_r%0d", 15 - i));
            sample_now();
        end
        expect_val(SEL_CNT, 16'd16, "wrCount_after_16");
        sample_now();

        // Bypass on both ports
        @(negedge clk);
        wrEnable = 1'b1; wrAddr = 4'd5; wrData = 16'h0001;
        @(negedge clk);
        wrEnable = 1'b0; rdAddrA = 4'd5; rdAddrB = 4'd5;
        expect_val(SEL_A, 16'h0001, "r5_stored_A");
        expect_val(SEL_B, 16'h0001, "r5_stored_B");
        sample_now();
        wrEnable = 1'b1; wrData = 16'hA5A5;
        expect_val(SEL_A, 16'hA5A5, "bypassA_pre_edge");
        expect_val(SEL_B, 16'hA5A5, "bypassB_pre_edge");
        sample_now();
        @(negedge clk);
        wrEnable = 1'b0;
        expect_val(SEL_A, 16'hA5A5, "r5_post_edge_A");
        expect_val(SEL_B, 16'hA5A5, "r5_post_edge_B");
        expect_val(SEL_CNT, 16'd18, "wrCount_after_bypass");
        sample_now();

        // Register and flag writes on the same edge
        @(negedge clk);
        wrEnable = 1'b1; wrAddr = 4'd7; wrData = 16'h7777;
        flagsWrite = 1'b1; flagsIn = 5'b10101;
        rdAddrA = 4'd6; rdAddrB = 4'd8;
        expect_val(SEL_FLAGS, 16'h0000, "flags_not_bypassed");
        expect_val(SEL_A, 16'h1006, "r6_no_false_bypass");
        sample_now();
        @(negedge clk);
        wrEnable = 1'b0; flagsWrite = 1'b0;
        rdAddrA = 4'd7;
        expect_val(SEL_A, 16'h7777, "r7_written");
        expect_val(SEL_B, 16'h1008, "r8_unchanged");
        expect_val(SEL_FLAGS, 16'h0015, "flags_10101");
        sample_now();
        rdAddrA = 4'd6;
        expect_val(SEL_A, 16'h1006, "r6_unchanged");
        sample_now();

        // Flags have no same-cycle visibility and hold without strobe
        flagsWrite = 1'b1; flagsIn = 5'b01010;
        expect_val(SEL_FLAGS, 16'h0015, "flags_hold_pre_edge");
        sample_now();
        @(negedge clk);
        flagsWrite = 1'b0; flagsIn = 5'b11111;
        expect_val(SEL_FLAGS, 16'h000A, "flags_01010");
        sample_now();
        @(negedge clk);
        expect_val(SEL_FLAGS, 16'h000A, "flags_hold_no_strobe");
        sample_now();

        // Saturation: count is 19 here; 300 writes total
        rdAddrA = 4'd0; rdAddrB = 4'd1;
        write_burst(235);
        expect_val(SEL_CNT, 16'd254, "wrCount_254");
        sample_now();
        write_burst(1);
        expect_val(SEL_CNT, 16'd255, "wrCount_255");
        sample_now();
        write_burst(64);
        expect_val(SEL_CNT, 16'd255, "wrCount_saturated");
        expect_val(SEL_A, 16'd299, "r0_last_write");
        expect_val(SEL_B, 16'h1001, "r1_untouched");
        sample_now();

        // Reset dominates a live bypass and clears the counter
        wrEnable = 1'b1; wrAddr = 4'd2; wrData = 16'hFFFF; rdAddrA = 4'd2;
        reset = 1'b1;
        expect_val(SEL_A, 16'h0000, "reset_beats_bypass");
        expect_val(SEL_CNT, 16'h0000, "reset_clears_wrCount");
        sample_now();
        @(negedge clk);
        wrEnable = 1'b0;
        reset = 1'b0;
        rdAddrB = 4'd0;
        expect_val(SEL_A, 16'h0000, "r2_not_written_in_reset");
        expect_val(SEL_B, 16'h0000, "r0_cleared");
        expect_val(SEL_CNT, 16'h0000, "wrCount_zero_after_reset");
        sample_now();

        // First write after reset release is accepted
        @(negedge clk);
        wrEnable = 1'b1; wrAddr = 4'd2; wrData = 16'h1234;
        @(negedge clk);
        wrEnable = 1'b0;
        expect_val(SEL_A, 16'h1234, "first_write_after_reset");
        expect_val(SEL_CNT, 16'h0001, "wrCount_first_after_reset");
        sample_now();

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
